// File: rtl/sm83_pkg.sv
// Shared types for the SM83 instruction fetch unit.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;
    typedef logic [7:0]  instr_t;

    // Fetch sequencer states: opcode, CB suffix, immediate bytes, present to decoder
    typedef enum logic [2:0] {
        S_OP,
        S_CB,
        S_IMM_LO,
        S_IMM_HI,
        S_HOLD
    } fetch_state_t;

    // Total instruction length in bytes (opcode plus immediate)
    typedef enum logic [1:0] {
        LEN_1,
        LEN_2,
        LEN_3
    } oplen_t;

endpackage

// File: rtl/sm83_oplen.sv
// Opcode length and illegal-opcode lookup for the unprefixed SM83 opcode map.
module sm83_oplen
    import sm83_pkg::*;
(
    input  instr_t opcode,
    output oplen_t oplen,
    output logic   illegal
);

    // Length lookup: anything not listed (including illegal opcodes) is a single byte
    always_comb begin
        oplen = LEN_1;
        case (opcode)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                oplen = LEN_2;
            8'h01, 8'h11, 8'h21, 8'h31,
            8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA:
                oplen = LEN_3;
            default:
                oplen = LEN_1;
        endcase
    end

    // Holes in the opcode map
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:
                illegal = 1'b1;
            default:
                illegal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sm83_fetch.sv
// SM83 instruction fetch: reads opcode, optional CB suffix and immediate bytes
// one at a time from a byte bus and presents whole instructions to the decoder.
module sm83_fetch
    import sm83_pkg::*;
#(
    parameter addr_t RESET_PC = 16'h0000
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   mem_req,
    output addr_t  mem_addr,
    input  logic   mem_ack,
    input  data_t  mem_rdata,
    output logic   instr_valid,
    input  logic   instr_ready,
    output instr_t instr,
    output logic   is_cb,
    output addr_t  imm,
    output addr_t  instr_pc,
    output logic   illegal,
    input  logic   redirect_valid,
    input  addr_t  redirect_pc
);

    fetch_state_t state_reg;
    addr_t        pc_reg;
    instr_t       instr_reg;
    logic         is_cb_reg;
    addr_t        imm_reg;
    addr_t        instr_pc_reg;
    logic         illegal_reg;
    oplen_t       len_reg;
    logic         mem_req_reg;
    logic         instr_valid_reg;

    oplen_t       op_len;
    logic         op_illegal;

    // Classify the byte on the bus; only used when it is an opcode byte
    sm83_oplen u_oplen (
        .opcode  (mem_rdata),
        .oplen   (op_len),
        .illegal (op_illegal)
    );

    // Fetch sequencer; a redirect overrides everything, including a coincident ack
    // or handshake, and abandons any request still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_OP;
            pc_reg          <= RESET_PC;
            instr_reg       <= 8'h00;
            is_cb_reg       <= 1'b0;
            imm_reg         <= 16'h0000;
            instr_pc_reg    <= RESET_PC;
            illegal_reg     <= 1'b0;
            len_reg         <= LEN_1;
            mem_req_reg     <= 1'b1;
            instr_valid_reg <= 1'b0;
        end else if (redirect_valid) begin
            state_reg       <= S_OP;
            pc_reg          <= redirect_pc;
            is_cb_reg       <= 1'b0;
            mem_req_reg     <= 1'b1;
            instr_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_OP: begin
                    if (mem_ack) begin
                        pc_reg       <= pc_reg + 16'd1;
                        instr_reg    <= mem_rdata;
                        is_cb_reg    <= 1'b0;
                        imm_reg      <= 16'h0000;
                        instr_pc_reg <= pc_reg;
                        illegal_reg  <= op_illegal;
                        len_reg      <= op_len;
                        if (mem_rdata == 8'hCB) begin
                            state_reg <= S_CB;
                        end else if (op_len == LEN_1) begin
                            state_reg       <= S_HOLD;
                            mem_req_reg     <= 1'b0;
                            instr_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= S_IMM_LO;
                        end
                    end
                end
                S_CB: begin
                    if (mem_ack) begin
                        pc_reg          <= pc_reg + 16'd1;
                        instr_reg       <= mem_rdata;
                        is_cb_reg       <= 1'b1;
                        state_reg       <= S_HOLD;
                        mem_req_reg     <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                S_IMM_LO: begin
                    if (mem_ack) begin
                        pc_reg        <= pc_reg + 16'd1;
                        imm_reg[7:0]  <= mem_rdata;
                        if (len_reg == LEN_3) begin
                            state_reg <= S_IMM_HI;
                        end else begin
                            state_reg       <= S_HOLD;
                            mem_req_reg     <= 1'b0;
                            instr_valid_reg <= 1'b1;
                        end
                    end
                end
                S_IMM_HI: begin
                    if (mem_ack) begin
                        pc_reg          <= pc_reg + 16'd1;
                        imm_reg[15:8]   <= mem_rdata;
                        state_reg       <= S_HOLD;
                        mem_req_reg     <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        state_reg       <= S_OP;
                        mem_req_reg     <= 1'b1;
                        instr_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= S_OP;
                    mem_req_reg     <= 1'b1;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_addr    = pc_reg;
    assign instr_valid = instr_valid_reg;
    assign instr       = instr_reg;
    assign is_cb       = is_cb_reg;
    assign imm         = imm_reg;
    assign instr_pc    = instr_pc_reg;
    assign illegal     = illegal_reg;

endmodule

// File: tb/tb_sm83_fetch.sv
// Testbench for sm83_fetch: byte memory model with controllable ack, and a
// scoreboard of expected instructions popped at each decoder handshake.
module tb_sm83_fetch;
    import sm83_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   mem_req;
    addr_t  mem_addr;
    logic   mem_ack;
    data_t  mem_rdata;
    logic   instr_valid;
    logic   instr_ready = 1'b0;
    instr_t instr;
    logic   is_cb;
    addr_t  imm;
    addr_t  instr_pc;
    logic   illegal;
    logic   redirect_valid = 1'b0;
    addr_t  redirect_pc = 16'h0000;
    logic   ack_en = 1'b0;

    logic [7:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imv;
        logic [15:0] pc;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_g;

    always #5 clk = ~clk;

    // Zero-wait memory whenever ack_en is high
    assign mem_ack   = mem_req & ack_en;
    assign mem_rdata = mem[mem_addr];

    sm83_fetch #(.RESET_PC(16'h0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .is_cb          (is_cb),
        .imm            (imm),
        .instr_pc       (instr_pc),
        .illegal        (illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Reference opcode length table
    function automatic int tb_len(input logic [7:0] op);
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h10,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8: return 2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic tb_illegal(input logic [7:0] op);
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: sample mid-cycle, after the bench has driven instr_ready,
    // so valid&&ready here is the handshake the next rising edge completes
    always @(negedge clk) begin
        #3;
        if (rst_n && instr_valid && instr_ready) begin
            mon_g = '{op: instr, cb: is_cb, imv: imm, pc: instr_pc, ill: illegal};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL txn_unexpected: got pc=%h instr=%h cb=%0d imm=%h ill=%0d, required none",
                         mon_g.pc, mon_g.op, mon_g.cb, mon_g.imv, mon_g.ill);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g !== mon_e) begin
                    errors++;
                    $display("FAIL txn: got pc=%h instr=%h cb=%0d imm=%h ill=%0d, required pc=%h instr=%h cb=%0d imm=%h ill=%0d",
                             mon_g.pc, mon_g.op, mon_g.cb, mon_g.imv, mon_g.ill,
                             mon_e.pc, mon_e.op, mon_e.cb, mon_e.imv, mon_e.ill);
                end else begin
                    $display("txn pc=%h instr=%h cb=%0d imm=%h ill=%0d",
                             mon_g.pc, mon_g.op, mon_g.cb, mon_g.imv, mon_g.ill);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        ack_en = 1'b0;
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Run until the scoreboard is empty, then stop the memory from acking
    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        ack_en = 1'b0;
    endtask

    task automatic test_nop();
        bit ok;
        do_reset();
        mem[16'h0100] = 8'h00;
        exp_q.push_back('{op: 8'h00, cb: 1'b0, imv: 16'h0000, pc: 16'h0100, ill: 1'b0});
        ack_en = 1'b1;
        instr_ready = 1'b1;
        drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nop_timeout: queue=%0d, required 0", exp_q.size()); end
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0101}) begin
            errors++;
            $display("FAIL nop_next_fetch: got req=%0d addr=%h, required req=1 addr=0101", mem_req, mem_addr);
        end
    endtask

    task automatic test_jp();
        bit ok;
        do_reset();
        mem[16'h0100] = 8'hC3; mem[16'h0101] = 8'h50; mem[16'h0102] = 8'h01;
        exp_q.push_back('{op: 8'hC3, cb: 1'b0, imv: 16'h0150, pc: 16'h0100, ill: 1'b0});
        ack_en = 1'b1;
        instr_ready = 1'b1;
        drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL jp_timeout: queue=%0d, required 0", exp_q.size()); end
        checks++;
        if ({mem_addr, instr_pc} !== {16'h0103, 16'h0100}) begin
            errors++;
            $display("FAIL jp_next_fetch: got addr=%h instr_pc=%h, required addr=0103 instr_pc=0100", mem_addr, instr_pc);
        end
    endtask

    // Asynchronous reset applied between clock edges with a dirty DUT
    task automatic test_reset();
        instr_ready = 1'b0;
        ack_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_addr, instr_valid, instr, is_cb, imm, instr_pc, illegal} !==
            {16'h0100, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0100, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got addr=%h valid=%0d instr=%h cb=%0d imm=%h pc=%h ill=%0d, required 0100 0 00 0 0000 0100 0",
                     mem_addr, instr_valid, instr, is_cb, imm, instr_pc, illegal);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0100, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_req: got req=%0d addr=%h valid=%0d, required 1 0100 0", mem_req, mem_addr, instr_valid);
        end
    endtask

    task automatic test_cb();
        bit ok;
        do_reset();
        mem[16'h0100] = 8'hCB; mem[16'h0101] = 8'h37;
        exp_q.push_back('{op: 8'h37, cb: 1'b1, imv: 16'h0000, pc: 16'h0100, ill: 1'b0});
        ack_en = 1'b1;
        instr_ready = 1'b1;
        drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cb_timeout: queue=%0d, required 0", exp_q.size()); end
        checks++;
        if (mem_addr !== 16'h0102) begin
            errors++;
            $display("FAIL cb_next_fetch: got addr=%h, required 0102", mem_addr);
        end
    endtask

    task automatic test_stall();
        bit seen;
        do_reset();
        mem[16'h0100] = 8'h3E; mem[16'h0101] = 8'h42;
        exp_q.push_back('{op: 8'h3E, cb: 1'b0, imv: 16'h0042, pc: 16'h0100, ill: 1'b0});
        ack_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (instr_valid) begin seen = 1'b1; break; end
        end
        ack_en = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_valid_timeout: got valid=0, required 1"); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({instr_valid, mem_req, instr, is_cb, imm, instr_pc, illegal} !==
                {1'b1, 1'b0, 8'h3E, 1'b0, 16'h0042, 16'h0100, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: got valid=%0d req=%0d instr=%h cb=%0d imm=%h pc=%h ill=%0d, required 1 0 3e 0 0042 0100 0",
                         instr_valid, mem_req, instr, is_cb, imm, instr_pc, illegal);
            end
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if ({mem_req, mem_addr, exp_q.size() == 0} !== {1'b1, 16'h0102, 1'b1}) begin
            errors++;
            $display("FAIL stall_accept: got req=%0d addr=%h queue=%0d, required req=1 addr=0102 queue=0",
                     mem_req, mem_addr, exp_q.size());
        end
    endtask

    task automatic test_redirect();
        bit hit;
        bit ok;
        do_reset();
        mem[16'h0100] = 8'hC3; mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22;
        mem[16'h0038] = 8'h00;
        ack_en = 1'b1;
        instr_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_addr == 16'h0102) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL redirect_imm_hi_timeout: got addr=%h, required 0102", mem_addr); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0038;
        step();
        redirect_valid = 1'b0;
        ack_en = 1'b0;
        checks++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0038, 1'b0}) begin
            errors++;
            $display("FAIL redirect_target: got req=%0d addr=%h valid=%0d, required 1 0038 0", mem_req, mem_addr, instr_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_no_valid: got valid=%0d, required 0", instr_valid);
            end
        end
        exp_q.push_back('{op: 8'h00, cb: 1'b0, imv: 16'h0000, pc: 16'h0038, ill: 1'b0});
        ack_en = 1'b1;
        drain(20, ok);
        checks++;
        if (!ok || mem_addr !== 16'h0039) begin
            errors++;
            $display("FAIL redirect_resume: got ok=%0d addr=%h, required ok=1 addr=0039", ok, mem_addr);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        mem[16'hFFFF] = 8'h18; mem[16'h0000] = 8'h05;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (mem_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_start: got addr=%h, required ffff", mem_addr);
        end
        exp_q.push_back('{op: 8'h18, cb: 1'b0, imv: 16'h0005, pc: 16'hFFFF, ill: 1'b0});
        ack_en = 1'b1;
        instr_ready = 1'b1;
        step();
        checks++;
        if (mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_imm_addr: got addr=%h, required 0000", mem_addr);
        end
        drain(20, ok);
        checks++;
        if (!ok || mem_addr !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_next_op: got ok=%0d addr=%h, required ok=1 addr=0001", ok, mem_addr);
        end
    endtask

    // Mixed stream with random memory wait states and decoder back-pressure
    task automatic test_back_to_back();
        logic [7:0]  ops [11];
        logic [15:0] a;
        logic [15:0] paddr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          n;
        bit          pend;
        ops = '{8'h00, 8'hDD, 8'hCB, 8'h3E, 8'h01, 8'hC3, 8'hE0, 8'hF4, 8'hCD, 8'h18, 8'hD3};
        do_reset();
        a = 16'h0100;
        for (int i = 0; i < 11; i++) begin
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            mem[a] = ops[i];
            if (ops[i] == 8'hCB) begin
                mem[a + 16'd1] = b0;
                exp_q.push_back('{op: b0, cb: 1'b1, imv: 16'h0000, pc: a, ill: 1'b0});
                a = a + 16'd2;
            end else begin
                n = tb_len(ops[i]);
                if (n >= 2) mem[a + 16'd1] = b0;
                if (n == 3) mem[a + 16'd2] = b1;
                exp_q.push_back('{op: ops[i], cb: 1'b0,
                                  imv: (n == 1) ? 16'h0000 : (n == 2) ? {8'h00, b0} : {b1, b0},
                                  pc: a, ill: tb_illegal(ops[i])});
                a = a + 16'(n);
            end
        end
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            ack_en = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            pend = mem_req && !ack_en;
            paddr = mem_addr;
            step();
            if (pend) begin
                checks++;
                if (mem_addr !== paddr) begin
                    errors++;
                    $display("FAIL b2b_addr_stable: got addr=%h, required %h", mem_addr, paddr);
                end
            end
        end
        ack_en = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || mem_addr !== a) begin
            errors++;
            $display("FAIL b2b_end: got queue=%0d addr=%h, required queue=0 addr=%h", exp_q.size(), mem_addr, a);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_nop();
        test_jp();
        test_reset();
        test_cb();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
